// File: rtl/alu_cond_unit_pkg.sv
// Shared definitions for the ALU flag consumer: opcodes, condition codes,
// NZCV bit positions and the condition-request FSM encoding.
package alu_cond_unit_pkg;

   localparam logic [3:0] alu_and = 4'b0000;
   localparam logic [3:0] alu_eor = 4'b0001;
   localparam logic [3:0] alu_orr = 4'b0010;
   localparam logic [3:0] alu_bic = 4'b0011;
   localparam logic [3:0] alu_mov = 4'b0100;
   localparam logic [3:0] alu_mvn = 4'b0101;
   localparam logic [3:0] alu_tst = 4'b0110;
   localparam logic [3:0] alu_add = 4'b0111;
   localparam logic [3:0] alu_sub = 4'b1000;
   localparam logic [3:0] alu_adc = 4'b1001;
   localparam logic [3:0] alu_sbc = 4'b1010;

   localparam logic [3:0] cond_eq = 4'b0000;
   localparam logic [3:0] cond_ne = 4'b0001;
   localparam logic [3:0] cond_cs = 4'b0010;
   localparam logic [3:0] cond_cc = 4'b0011;
   localparam logic [3:0] cond_mi = 4'b0100;
   localparam logic [3:0] cond_pl = 4'b0101;
   localparam logic [3:0] cond_vs = 4'b0110;
   localparam logic [3:0] cond_vc = 4'b0111;
   localparam logic [3:0] cond_hi = 4'b1000;
   localparam logic [3:0] cond_ls = 4'b1001;
   localparam logic [3:0] cond_ge = 4'b1010;
   localparam logic [3:0] cond_lt = 4'b1011;
   localparam logic [3:0] cond_gt = 4'b1100;
   localparam logic [3:0] cond_le = 4'b1101;
   localparam logic [3:0] cond_al = 4'b1110;
   localparam logic [3:0] cond_nv = 4'b1111;

   localparam int unsigned flag_n = 3;
   localparam int unsigned flag_z = 2;
   localparam int unsigned flag_c = 1;
   localparam int unsigned flag_v = 0;

   typedef enum logic [1:0] {
      st_idle = 2'd0,
      st_wait = 2'd1,
      st_resp = 2'd2
   } state_e;

   function automatic logic is_logic(input logic [3:0] op);
      return op inside {alu_and, alu_eor, alu_orr, alu_bic, alu_mov, alu_mvn, alu_tst};
   endfunction

   function automatic logic is_arith(input logic [3:0] op);
      return op inside {alu_add, alu_sub, alu_adc, alu_sbc};
   endfunction

endpackage

// File: rtl/alu_cond_unit_cond_eval.sv
// Purely combinational ARM condition-code evaluator over {N,Z,C,V}.
// Shared with the branch unit.
module alu_cond_unit_cond_eval
   import alu_cond_unit_pkg::*;
(
   input  logic [3:0] cond_code,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic n, z, c, v;

   assign n = nzcv[flag_n];
   assign z = nzcv[flag_z];
   assign c = nzcv[flag_c];
   assign v = nzcv[flag_v];

   always_comb begin
      pass = 1'b0;
      case (cond_code)
         cond_eq: pass = z;
         cond_ne: pass = !z;
         cond_cs: pass = c;
         cond_cc: pass = !c;
         cond_mi: pass = n;
         cond_pl: pass = !n;
         cond_vs: pass = v;
         cond_vc: pass = !v;
         cond_hi: pass = c & !z;
         cond_ls: pass = !c | z;
         cond_ge: pass = (n == v);
         cond_lt: pass = (n != v);
         cond_gt: pass = !z & (n == v);
         cond_le: pass = z | (n != v);
         cond_al: pass = 1'b1;
         cond_nv: pass = 1'b0;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_cond_unit.sv
// NZCV status register, in-flight flag-op tracking and condition evaluation
// with flag forwarding. Optional pass/fail counters under COND_STATS_EN.
module alu_cond_unit
   import alu_cond_unit_pkg::*;
#(
   parameter int unsigned PEND_W    = 3,
   parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        issue_flagset,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic        alu_s,
   input  logic [3:0]  alu_op,
   input  logic        alu_n,
   input  logic        alu_z,
   input  logic        alu_v,
   input  logic        alu_co,
   input  logic        cond_valid,
   output logic        cond_ready,
   input  logic [3:0]  cond_code,
   output logic        pass_valid,
   input  logic        pass_ready,
   output logic        pass,
   output logic [3:0]  flags,
`ifdef COND_STATS_EN
   output logic [15:0] pass_cnt,
   output logic [15:0] fail_cnt,
`endif
   output logic        pend_err
);

   localparam logic [PEND_W-1:0] pend_max = {PEND_W{1'b1}};

   state_e            state_q;
   logic [3:0]        flags_q, fwd;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              err_q, err_d;
   logic [3:0]        code_q, eval_code;
   logic              pass_q, pass_valid_q, cond_ready_q;
   logic              inc, dec, legal, eval_pass;

   assign inc = issue_flagset;
   assign dec = alu_valid & alu_s;

   // Flags as they will be after this cycle's ALU write.
   always_comb begin
      fwd = flags_q;
      if (dec) begin
         if (is_logic(alu_op)) begin
            fwd[flag_n] = alu_n;
            fwd[flag_z] = alu_z;
         end else if (is_arith(alu_op)) begin
            fwd[flag_n] = alu_n;
            fwd[flag_z] = alu_z;
            fwd[flag_c] = alu_co;
            fwd[flag_v] = alu_v;
         end
      end
   end

   always_comb begin
      pend_d = pend_q;
      err_d  = err_q;
      if (inc && !dec) begin
         if (pend_q == pend_max) err_d = 1'b1;
         else                    pend_d = pend_q + 1'b1;
      end else if (dec && !inc) begin
         if (pend_q == '0) err_d = 1'b1;
         else              pend_d = pend_q - 1'b1;
      end
   end

   // Legal when no flag op is outstanding, or the last one lands this cycle.
   assign legal = (pend_q == '0) | ((pend_q == PEND_W'(1)) & dec & !inc);

   assign eval_code = (state_q == st_wait) ? code_q : cond_code;

   alu_cond_unit_cond_eval u_cond_eval (
      .cond_code (eval_code),
      .nzcv      (fwd),
      .pass      (eval_pass)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= st_idle;
         flags_q      <= FLAGS_RST;
         pend_q       <= '0;
         err_q        <= 1'b0;
         code_q       <= 4'b0000;
         pass_q       <= 1'b0;
         pass_valid_q <= 1'b0;
         cond_ready_q <= 1'b0;
      end else begin
         flags_q <= fwd;
         pend_q  <= pend_d;
         err_q   <= err_d;
         case (state_q)
            st_idle: begin
               cond_ready_q <= 1'b1;
               if (cond_valid && cond_ready_q) begin
                  cond_ready_q <= 1'b0;
                  if (legal) begin
                     pass_q       <= eval_pass;
                     pass_valid_q <= 1'b1;
                     state_q      <= st_resp;
                  end else begin
                     code_q  <= cond_code;
                     state_q <= st_wait;
                  end
               end
            end
            st_wait: begin
               cond_ready_q <= 1'b0;
               if (legal) begin
                  pass_q       <= eval_pass;
                  pass_valid_q <= 1'b1;
                  state_q      <= st_resp;
               end
            end
            st_resp: begin
               cond_ready_q <= pass_ready;
               if (pass_ready) begin
                  pass_valid_q <= 1'b0;
                  state_q      <= st_idle;
               end
            end
            default: begin
               cond_ready_q <= 1'b0;
               pass_valid_q <= 1'b0;
               state_q      <= st_idle;
            end
         endcase
      end
   end

`ifdef COND_STATS_EN
   logic [15:0] pass_cnt_q, fail_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         pass_cnt_q <= 16'h0000;
         fail_cnt_q <= 16'h0000;
      end else if (pass_valid_q && pass_ready) begin
         if (pass_q) begin
            if (pass_cnt_q != 16'hFFFF) pass_cnt_q <= pass_cnt_q + 16'h0001;
         end else begin
            if (fail_cnt_q != 16'hFFFF) fail_cnt_q <= fail_cnt_q + 16'h0001;
         end
      end
   end

   assign pass_cnt = pass_cnt_q;
   assign fail_cnt = fail_cnt_q;
`endif

   assign alu_ready  = !reset;
   assign cond_ready = cond_ready_q;
   assign pass_valid = pass_valid_q;
   assign pass       = pass_q;
   assign flags      = flags_q;
   assign pend_err   = err_q;

endmodule

// File: tb/tb_alu_cond_unit.sv
// Directed self-checking bench for alu_cond_unit (default parameters).
module tb_alu_cond_unit;

   logic        clk = 1'b0;
   logic        reset, issue_flagset, alu_valid, alu_s;
   logic [3:0]  alu_op, cond_code;
   logic        alu_n, alu_z, alu_v, alu_co;
   logic        cond_valid, pass_ready;
   logic        alu_ready, cond_ready, pass_valid, pass, pend_err;
   logic [3:0]  flags;
`ifdef COND_STATS_EN
   logic [15:0] pass_cnt, fail_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_cond_unit dut (
      .clk           (clk),
      .reset         (reset),
      .issue_flagset (issue_flagset),
      .alu_valid     (alu_valid),
      .alu_ready     (alu_ready),
      .alu_s         (alu_s),
      .alu_op        (alu_op),
      .alu_n         (alu_n),
      .alu_z         (alu_z),
      .alu_v         (alu_v),
      .alu_co        (alu_co),
      .cond_valid    (cond_valid),
      .cond_ready    (cond_ready),
      .cond_code     (cond_code),
      .pass_valid    (pass_valid),
      .pass_ready    (pass_ready),
      .pass          (pass),
      .flags         (flags),
`ifdef COND_STATS_EN
      .pass_cnt      (pass_cnt),
      .fail_cnt      (fail_cnt),
`endif
      .pend_err      (pend_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One-cycle ALU flag write.
   task automatic alu_write(input logic [3:0] op, input logic n, input logic z,
                            input logic v, input logic co);
      alu_valid = 1'b1; alu_s = 1'b1; alu_op = op;
      alu_n = n; alu_z = z; alu_v = v; alu_co = co;
      tick();
      alu_valid = 1'b0; alu_s = 1'b0;
   endtask

   task automatic flag_op(input logic [3:0] op, input logic n, input logic z,
                          input logic v, input logic co);
      issue_flagset = 1'b1;
      tick();
      issue_flagset = 1'b0;
      alu_write(op, n, z, v, co);
   endtask

   // Request with flags current: result must appear the next cycle.
   task automatic req(input string tag, input logic [3:0] code, input logic exp);
      cond_valid = 1'b1; cond_code = code;
      tick();
      cond_valid = 1'b0;
      check({tag, "_pv"}, 16'(pass_valid), 16'd1);
      check({tag, "_pass"}, 16'(pass), 16'(exp));
      pass_ready = 1'b1;
      tick();
      pass_ready = 1'b0;
      check({tag, "_idle"}, 16'(pass_valid), 16'd0);
   endtask

   initial begin
      reset = 1'b1; issue_flagset = 1'b0; alu_valid = 1'b0; alu_s = 1'b0;
      alu_op = 4'd0; alu_n = 1'b0; alu_z = 1'b0; alu_v = 1'b0; alu_co = 1'b0;
      cond_valid = 1'b0; cond_code = 4'd0; pass_ready = 1'b0;
      tick();
      tick();
      check("rst_flags", 16'(flags), 16'h0);
      check("rst_crdy", 16'(cond_ready), 16'd0);
      check("rst_pv", 16'(pass_valid), 16'd0);
      check("rst_pass", 16'(pass), 16'd0);
      check("rst_err", 16'(pend_err), 16'd0);
      check("rst_ardy", 16'(alu_ready), 16'd0);
      reset = 1'b0;
      tick();
      check("crdy_up", 16'(cond_ready), 16'd1);
      check("ardy_up", 16'(alu_ready), 16'd1);

      req("al", 4'b1110, 1'b1);
      check("al_flags", 16'(flags), 16'h0);
      req("nv", 4'b1111, 1'b0);

      // Arithmetic write: N=0 Z=0 C=1 V=1.
      flag_op(4'b0111, 1'b0, 1'b0, 1'b1, 1'b1);
      check("arith_flags", 16'(flags), 16'h3);
      check("arith_err", 16'(pend_err), 16'd0);
      req("ge", 4'b1010, 1'b0);
      req("vs", 4'b0110, 1'b1);

      // Logical write keeps C,V.
      flag_op(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
      check("logic_flags", 16'(flags), 16'h7);
      req("hi", 4'b1000, 1'b0);
      req("ls", 4'b1001, 1'b1);

      // Result without alu_s: nothing changes.
      alu_valid = 1'b1; alu_s = 1'b0; alu_op = 4'b0111;
      alu_n = 1'b1; alu_z = 1'b0; alu_v = 1'b0; alu_co = 1'b0;
      tick();
      alu_valid = 1'b0;
      check("nos_flags", 16'(flags), 16'h7);
      check("nos_err", 16'(pend_err), 16'd0);

      flag_op(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
      check("sub_flags", 16'(flags), 16'h8);
      req("gt", 4'b1100, 1'b0);
      req("lt", 4'b1011, 1'b1);

      // Stall behind an outstanding op, then forward its Z.
      issue_flagset = 1'b1;
      tick();
      issue_flagset = 1'b0;
      cond_valid = 1'b1; cond_code = 4'b0000;
      tick();
      cond_valid = 1'b0;
      check("wait_pv", 16'(pass_valid), 16'd0);
      check("wait_crdy", 16'(cond_ready), 16'd0);
      tick();
      check("wait_pv2", 16'(pass_valid), 16'd0);
      alu_write(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
      check("fwd_pv", 16'(pass_valid), 16'd1);
      check("fwd_pass", 16'(pass), 16'd1);
      check("fwd_flags", 16'(flags), 16'h4);

      // Back-pressure: result held stable.
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_pv", 16'(pass_valid), 16'd1);
         check("hold_pass", 16'(pass), 16'd1);
         check("hold_crdy", 16'(cond_ready), 16'd0);
      end
      pass_ready = 1'b1;
      tick();
      pass_ready = 1'b0;
      check("rel_pv", 16'(pass_valid), 16'd0);
      check("rel_crdy", 16'(cond_ready), 16'd1);

      // Eight issues: counter saturates at 7 and flags the overflow.
      issue_flagset = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      check("sat7_err", 16'(pend_err), 16'd0);
      tick();
      issue_flagset = 1'b0;
      check("sat8_err", 16'(pend_err), 16'd1);
      cond_valid = 1'b1; cond_code = 4'b1110;
      tick();
      cond_valid = 1'b0;
      check("sat_wait", 16'(pass_valid), 16'd0);
      // Six retirements leave one pending (unknown opcode: flags untouched).
      for (int i = 0; i < 6; i++) alu_write(4'b1011, 1'b1, 1'b1, 1'b1, 1'b1);
      check("sat_still_wait", 16'(pass_valid), 16'd0);
      check("other_op_flags", 16'(flags), 16'h4);
      alu_write(4'b1011, 1'b1, 1'b1, 1'b1, 1'b1);
      check("sat_done_pv", 16'(pass_valid), 16'd1);
      check("sat_done_pass", 16'(pass), 16'd1);
      check("sat_err_sticky", 16'(pend_err), 16'd1);
      pass_ready = 1'b1;
      tick();
      pass_ready = 1'b0;

      // Reset while in WAIT drops the request.
      issue_flagset = 1'b1;
      tick();
      issue_flagset = 1'b0;
      cond_valid = 1'b1; cond_code = 4'b0000;
      tick();
      cond_valid = 1'b0;
      check("pre_rst_crdy", 16'(cond_ready), 16'd0);
      reset = 1'b1;
      tick();
      check("mid_rst_flags", 16'(flags), 16'h0);
      check("mid_rst_crdy", 16'(cond_ready), 16'd0);
      check("mid_rst_pv", 16'(pass_valid), 16'd0);
      check("mid_rst_pass", 16'(pass), 16'd0);
      check("mid_rst_err", 16'(pend_err), 16'd0);
      check("mid_rst_ardy", 16'(alu_ready), 16'd0);
      reset = 1'b0;
      tick();
      tick();
      check("post_rst_pv", 16'(pass_valid), 16'd0);
      check("post_rst_crdy", 16'(cond_ready), 16'd1);
      req("post_rst_eq", 4'b0000, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
